// File: rtl/lbp_window_sched.sv
// Raster-scan 3x3 window scheduler for the LBP datapath.
// Fetches gray pixels and emits one window per interior pixel.
module lbp_window_sched #(
  parameter int W      = 128,
  parameter int H      = 128,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic              gray_ready,
  input  logic [7:0]        gray_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [71:0]       win_data,
  output logic [ADDR_W-1:0] win_addr,
  output logic              busy,
  output logic              finish
);

  localparam int CW = $clog2(W);
  localparam int RW = ADDR_W - CW;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EMIT,
    DONE
  } state_t;

  state_t        state, n_state;
  logic [RW-1:0] row, n_row;
  logic [CW-1:0] col, n_col;
  logic [CW-1:0] fcol, n_fcol;
  logic [1:0]    j, n_j;
  logic          rs, n_rs;
  logic [71:0]   n_win;
  logic [RW-1:0] arow;

  always_comb begin
    n_state = state;
    n_row   = row;
    n_col   = col;
    n_fcol  = fcol;
    n_j     = j;
    n_rs    = rs;
    n_win   = win_data;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          n_state = FETCH;
          n_row   = RW'(1);
          n_col   = CW'(1);
          n_fcol  = '0;
          n_j     = '0;
          n_rs    = 1'b1;
        end
      end
      FETCH: begin
        if (gray_ready) begin
          // window row j is three bytes: left, mid, right
          unique case (j)
            2'd0:    n_win[23:0]  = {gray_data, win_data[23:8]};
            2'd1:    n_win[47:24] = {gray_data, win_data[47:32]};
            default: n_win[71:48] = {gray_data, win_data[71:56]};
          endcase
          if (j == 2'd2) begin
            n_j = '0;
            if (rs && fcol < CW'(2)) begin
              n_fcol = fcol + CW'(1);
            end else begin
              n_state = EMIT;
              n_rs    = 1'b0;
            end
          end else begin
            n_j = j + 2'd1;
          end
        end
      end
      EMIT: begin
        if (win_ready) begin
          if (col < CW'(W - 2)) begin
            n_col   = col + CW'(1);
            n_fcol  = col + CW'(2);
            n_j     = '0;
            n_state = FETCH;
          end else if (row < RW'(H - 2)) begin
            n_row   = row + RW'(1);
            n_col   = CW'(1);
            n_fcol  = '0;
            n_j     = '0;
            n_rs    = 1'b1;
            n_state = FETCH;
          end else begin
            n_state = DONE;
          end
        end
      end
      default: n_state = IDLE;
    endcase
    arow = n_row - RW'(1) + RW'(n_j);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      fcol      <= '0;
      j         <= '0;
      rs        <= 1'b0;
      win_data  <= '0;
      gray_req  <= 1'b0;
      gray_addr <= '0;
      win_valid <= 1'b0;
      win_addr  <= '0;
      busy      <= 1'b0;
      finish    <= 1'b0;
    end else begin
      state     <= n_state;
      row       <= n_row;
      col       <= n_col;
      fcol      <= n_fcol;
      j         <= n_j;
      rs        <= n_rs;
      win_data  <= n_win;
      gray_req  <= (n_state == FETCH);
      gray_addr <= (n_state == FETCH) ? {arow, n_fcol} : '0;
      win_valid <= (n_state == EMIT);
      win_addr  <= {n_row, n_col};
      busy      <= (n_state == FETCH) || (n_state == EMIT);
      finish    <= (n_state == DONE);
    end
  end

endmodule

// File: tb/tb_lbp_window_sched.sv
// Bench for lbp_window_sched: small 8x4 image scenarios
// and a full 128x128 scan, scoreboard checked.
module tb_lbp_window_sched;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [71:0] got, logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(int a);
    return 8'(a ^ (a >> 8));
  endfunction

  function automatic logic [71:0] ewin(int a, int w);
    logic [71:0] r;
    r = '0;
    for (int k = 0; k < 9; k++)
      r[8*k +: 8] = pix(a + (k / 3 - 1) * w + (k % 3 - 1));
    return r;
  endfunction

  // small instance, 8x4
  logic        s_start = 1'b0;
  logic        s_gray_req;
  logic [4:0]  s_gray_addr;
  logic        s_gray_ready = 1'b1;
  logic [7:0]  s_gray_data;
  logic        s_win_valid;
  logic        s_win_ready = 1'b1;
  logic [71:0] s_win_data;
  logic [4:0]  s_win_addr;
  logic        s_busy;
  logic        s_finish;

  assign s_gray_data = pix(int'(s_gray_addr));

  lbp_window_sched #(.W(8), .H(4), .ADDR_W(5)) u_s (
    .clk        (clk),
    .reset      (reset),
    .start      (s_start),
    .gray_req   (s_gray_req),
    .gray_addr  (s_gray_addr),
    .gray_ready (s_gray_ready),
    .gray_data  (s_gray_data),
    .win_valid  (s_win_valid),
    .win_ready  (s_win_ready),
    .win_data   (s_win_data),
    .win_addr   (s_win_addr),
    .busy       (s_busy),
    .finish     (s_finish)
  );

  // full-size instance
  logic        b_start = 1'b0;
  logic        b_gray_req;
  logic [13:0] b_gray_addr;
  logic [7:0]  b_gray_data;
  logic        b_win_valid;
  logic [71:0] b_win_data;
  logic [13:0] b_win_addr;
  logic        b_busy;
  logic        b_finish;

  assign b_gray_data = pix(int'(b_gray_addr));

  lbp_window_sched u_b (
    .clk        (clk),
    .reset      (reset),
    .start      (b_start),
    .gray_req   (b_gray_req),
    .gray_addr  (b_gray_addr),
    .gray_ready (1'b1),
    .gray_data  (b_gray_data),
    .win_valid  (b_win_valid),
    .win_ready  (1'b1),
    .win_data   (b_win_data),
    .win_addr   (b_win_addr),
    .busy       (b_busy),
    .finish     (b_finish)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [71:0] data;
  } item_t;

  item_t sq[$];
  int    s_wins = 0;
  int    s_reads = 0;
  int    scan_no = 0;
  int    wrap_i = 9;
  bit    s_fin_pend = 1'b0;
  int    wrap_exp[9] = '{8, 16, 24, 9, 17, 25, 10, 18, 26};

  task automatic push_scan();
    for (int r = 1; r <= 2; r++)
      for (int c = 1; c <= 6; c++)
        sq.push_back({5'(r * 8 + c), ewin(r * 8 + c, 8)});
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (s_fin_pend) begin
        chk("s_fin_after", s_finish, 1);
        s_fin_pend = 1'b0;
      end
      if (s_gray_req && s_gray_ready) begin
        s_reads++;
        if (wrap_i < 9) begin
          chk("wrap_rd", s_gray_addr, wrap_exp[wrap_i]);
          wrap_i++;
        end
      end
      if (s_win_valid && s_win_ready) begin
        item_t e;
        s_wins++;
        if (sq.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          e = sq.pop_front();
          chk("s_win_addr", s_win_addr, e.addr);
          chk("s_win_data", s_win_data, e.data);
        end
        if (s_win_addr == 5'd14 && scan_no == 1) wrap_i = 0;
        if (s_win_addr == 5'd22) s_fin_pend = 1'b1;
      end
    end
  end

  int b_wins = 0;
  int b_reads = 0;
  int b_r = 1;
  int b_c = 1;
  int b_last = 0;
  bit b_fin_pend = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (b_fin_pend) begin
        chk("b_fin_after", b_finish, 1);
        b_fin_pend = 1'b0;
      end
      if (b_gray_req) b_reads++;
      if (b_win_valid) begin
        chk("b_win_addr", b_win_addr, b_r * 128 + b_c);
        chk("b_win_data", b_win_data, ewin(b_r * 128 + b_c, 128));
        b_wins++;
        b_last = int'(b_win_addr);
        if (b_c == 126) begin
          b_c = 1;
          b_r++;
        end else begin
          b_c++;
        end
        if (b_r == 127) b_fin_pend = 1'b1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic s_pulse();
    s_start = 1'b1;
    cyc();
    s_start = 1'b0;
  endtask

  task automatic s_wait_fin(string tag);
    int n;
    n = 0;
    while (!s_finish && n < 500) begin
      cyc();
      n++;
    end
    if (!s_finish) chk(tag, 0, 1);
  endtask

  task automatic s_reset_vals(string tag);
    chk({tag, "_req"}, s_gray_req, 0);
    chk({tag, "_gaddr"}, s_gray_addr, 0);
    chk({tag, "_valid"}, s_win_valid, 0);
    chk({tag, "_wdata"}, s_win_data, 0);
    chk({tag, "_waddr"}, s_win_addr, 0);
    chk({tag, "_busy"}, s_busy, 0);
    chk({tag, "_finish"}, s_finish, 0);
  endtask

  initial begin
    int n;
    int w0;
    int r0;
    repeat (3) cyc();
    s_reset_vals("rst");
    chk("b_rst_busy", b_busy, 0);
    reset = 1'b0;
    cyc();

    // scan 1: nominal run, latency, row wrap
    scan_no = 1;
    w0 = s_wins;
    r0 = s_reads;
    push_scan();
    s_pulse();
    chk("start_req", s_gray_req, 1);
    chk("start_addr", s_gray_addr, 0);
    chk("start_busy", s_busy, 1);
    n = 0;
    while (!s_win_valid && n < 50) begin
      cyc();
      n++;
    end
    chk("fill_lat", n, 9);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!(s_win_valid && s_win_addr == 5'd10) && n < 50);
    chk("steady_lat", n, 4);
    s_wait_fin("fin1_timeout");
    cyc();
    chk("s1_wins", s_wins - w0, 12);
    chk("s1_reads", s_reads - r0, 48);
    chk("s1_busy", s_busy, 0);
    chk("s1_sb_left", sq.size(), 0);

    // scan 2: read stall and window backpressure
    scan_no = 2;
    w0 = s_wins;
    push_scan();
    s_pulse();
    chk("restart_fin", s_finish, 0);
    n = 0;
    while (!(s_gray_req && s_gray_addr == 5'd11) && n < 100) begin
      cyc();
      n++;
    end
    chk("stall_found", s_gray_addr, 11);
    s_gray_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_addr", s_gray_addr, 11);
      chk("stall_valid", s_win_valid, 0);
    end
    s_gray_ready = 1'b1;
    n = 0;
    while (!(s_win_valid && s_win_addr == 5'd10) && n < 100) begin
      cyc();
      n++;
    end
    chk("bp_found", s_win_addr, 10);
    s_win_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("bp_addr", s_win_addr, 10);
      chk("bp_data", s_win_data, ewin(10, 8));
      chk("bp_req", s_gray_req, 0);
    end
    s_win_ready = 1'b1;
    s_wait_fin("fin2_timeout");
    cyc();
    chk("s2_wins", s_wins - w0, 12);
    chk("s2_sb_left", sq.size(), 0);

    // scan 3: reset during row 2 fetch, then rescan
    scan_no = 3;
    push_scan();
    s_pulse();
    n = 0;
    while (!(s_gray_req && s_gray_addr == 5'd24) && n < 200) begin
      cyc();
      n++;
    end
    chk("row2_found", s_gray_addr, 24);
    #2 reset = 1'b1;
    #1 s_reset_vals("mid_rst");
    sq.delete();
    cyc();
    reset = 1'b0;
    cyc();
    w0 = s_wins;
    push_scan();
    s_pulse();
    s_wait_fin("fin3_timeout");
    cyc();
    chk("s3_wins", s_wins - w0, 12);
    chk("s3_sb_left", sq.size(), 0);

    // full 128x128 scan with an ignored mid-scan start
    b_start = 1'b1;
    cyc();
    b_start = 1'b0;
    repeat (1000) cyc();
    b_start = 1'b1;
    cyc();
    b_start = 1'b0;
    chk("b_mid_busy", b_busy, 1);
    n = 0;
    while (!b_finish && n < 80000) begin
      cyc();
      n++;
    end
    if (!b_finish) chk("b_timeout", 0, 1);
    cyc();
    chk("b_wins", b_wins, 15876);
    chk("b_reads", b_reads, 48384);
    chk("b_last", b_last, 16254);
    chk("b_finish", b_finish, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
